// File: rtl/wb_rr_arbiter_wdt_if.sv
// Bus bundle for wb_rr_arbiter_wdt.
// Carries the packed master-side Wishbone ports (wbm_*), the single slave-side
// port (wbs_*), and the grant/timeout status outputs.
// Modports:
//   slave  - the arbiter's view. It accepts master requests and drives the slave port.
//   master - the environment's view. It drives the masters and the slave response.
interface wb_rr_arbiter_wdt_if #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned aw          = 32,
    parameter int unsigned dw          = 32
);
    localparam int unsigned SW = dw / 8;

    logic [NUM_MASTERS*aw-1:0] wbm_adr_i;
    logic [NUM_MASTERS*dw-1:0] wbm_dat_i;
    logic [NUM_MASTERS*SW-1:0] wbm_sel_i;
    logic [NUM_MASTERS-1:0]    wbm_we_i;
    logic [NUM_MASTERS-1:0]    wbm_cyc_i;
    logic [NUM_MASTERS-1:0]    wbm_stb_i;
    logic [NUM_MASTERS*3-1:0]  wbm_cti_i;
    logic [NUM_MASTERS*2-1:0]  wbm_bte_i;
    logic [NUM_MASTERS*dw-1:0] wbm_rdt_o;
    logic [NUM_MASTERS-1:0]    wbm_ack_o;
    logic [NUM_MASTERS-1:0]    wbm_err_o;
    logic [NUM_MASTERS-1:0]    wbm_rty_o;

    logic [aw-1:0]             wbs_adr_o;
    logic [dw-1:0]             wbs_dat_o;
    logic [SW-1:0]             wbs_sel_o;
    logic                      wbs_we_o;
    logic                      wbs_cyc_o;
    logic                      wbs_stb_o;
    logic [2:0]                wbs_cti_o;
    logic [1:0]                wbs_bte_o;
    logic [dw-1:0]             wbs_rdt_i;
    logic                      wbs_ack_i;
    logic                      wbs_err_i;
    logic                      wbs_rty_i;

    logic [NUM_MASTERS-1:0]    grant_o;
    logic                      timeout_o;

    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i,
        output wbm_rdt_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
               wbs_cti_o, wbs_bte_o,
        input  wbs_rdt_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        output grant_o, timeout_o
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i,
        input  wbm_rdt_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
               wbs_cti_o, wbs_bte_o,
        output wbs_rdt_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        input  grant_o, timeout_o
    );
endinterface

// File: rtl/wb_rr_arbiter_wdt.sv
// Round-robin Wishbone arbiter with a per-transfer watchdog.
// A grant is held for the owner's whole cyc, so bursts are never split.
// If the slave gives no ack/err/rty for TIMEOUT strobe cycles, the access is aborted
// and err is returned to the owner. TIMEOUT=0 disables the watchdog.
// Ports:
//   wb_clk_i - clock
//   wb_rst_i - asynchronous active-high reset
//   bus      - wb_rr_arbiter_wdt_if.slave, which carries:
//              wbm_*     packed master ports (master i at slice i)
//              wbs_*     shared slave port
//              grant_o   one-hot owner (0 when idle)
//              timeout_o one-cycle pulse on a watchdog abort
module wb_rr_arbiter_wdt #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned aw          = 32,
    parameter int unsigned dw          = 32,
    parameter int unsigned TIMEOUT     = 256
) (
    input logic                wb_clk_i,
    input logic                wb_rst_i,
    wb_rr_arbiter_wdt_if.slave bus
);
    localparam int unsigned SW = dw / 8;
    localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          WDT_ON = (TIMEOUT > 0);
    localparam logic [WW-1:0] WDT_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ABORT} state_t;

    state_t                 state;
    logic [IW-1:0]          owner;
    logic [IW-1:0]          last;
    logic [NUM_MASTERS-1:0] grant;
    logic [WW-1:0]          wdt;
    logic                   timeout;

    logic                   busy;
    logic                   resp;
    logic                   found;
    logic [IW-1:0]          winner;
    logic [IW-1:0]          cand;
    logic [31:0]            rr_sum;

    logic                   own_cyc;
    logic                   own_stb;
    logic [aw-1:0]          own_adr;
    logic [dw-1:0]          own_dat;
    logic [SW-1:0]          own_sel;
    logic                   own_we;
    logic [2:0]             own_cti;
    logic [1:0]             own_bte;

    logic [NUM_MASTERS-1:0] ack_vec;
    logic [NUM_MASTERS-1:0] err_vec;
    logic [NUM_MASTERS-1:0] rty_vec;

    assign busy = (state == S_BUSY);
    assign resp = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;

    // Round-robin search: first requester at last+1, last+2, ... (mod NUM_MASTERS).
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        rr_sum = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            rr_sum = 32'(last) + 32'(k);
            cand   = (rr_sum >= 32'(NUM_MASTERS)) ? IW'(rr_sum - 32'(NUM_MASTERS)) : IW'(rr_sum);
            if (!found && bus.wbm_cyc_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Select the owner's request signals.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cti = '0;
        own_bte = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (owner == IW'(i)) begin
                own_cyc = bus.wbm_cyc_i[i];
                own_stb = bus.wbm_stb_i[i];
                own_adr = bus.wbm_adr_i[i*aw +: aw];
                own_dat = bus.wbm_dat_i[i*dw +: dw];
                own_sel = bus.wbm_sel_i[i*SW +: SW];
                own_we  = bus.wbm_we_i[i];
                own_cti = bus.wbm_cti_i[i*3 +: 3];
                own_bte = bus.wbm_bte_i[i*2 +: 2];
            end
        end
    end

    // Slave port is driven only while BUSY, so reset or abort silences it at once.
    assign bus.wbs_cyc_o = busy & own_cyc;
    assign bus.wbs_stb_o = busy & own_stb;
    assign bus.wbs_adr_o = busy ? own_adr : '0;
    assign bus.wbs_dat_o = busy ? own_dat : '0;
    assign bus.wbs_sel_o = busy ? own_sel : '0;
    assign bus.wbs_we_o  = busy & own_we;
    assign bus.wbs_cti_o = busy ? own_cti : '0;
    assign bus.wbs_bte_o = busy ? own_bte : '0;

    // Responses reach only the owner. In ABORT, err is forced and a late ack is dropped.
    always_comb begin
        ack_vec = '0;
        err_vec = '0;
        rty_vec = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (owner == IW'(i)) begin
                ack_vec[i] = busy & bus.wbs_ack_i;
                err_vec[i] = (busy & bus.wbs_err_i) | (state == S_ABORT);
                rty_vec[i] = busy & bus.wbs_rty_i;
            end
        end
    end

    assign bus.wbm_ack_o = ack_vec;
    assign bus.wbm_err_o = err_vec;
    assign bus.wbm_rty_o = rty_vec;
    assign bus.wbm_rdt_o = {NUM_MASTERS{bus.wbs_rdt_i}};
    assign bus.grant_o   = grant;
    assign bus.timeout_o = timeout;

    // Arbitration FSM and watchdog.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= S_IDLE;
            owner   <= '0;
            last    <= IW'(NUM_MASTERS - 1);
            grant   <= '0;
            wdt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    wdt <= '0;
                    if (found) begin
                        state <= S_BUSY;
                        owner <= winner;
                        last  <= winner;
                        grant <= NUM_MASTERS'(1) << winner;
                    end
                end
                S_BUSY: begin
                    if (!own_cyc) begin
                        state <= S_IDLE;
                        grant <= '0;
                        wdt   <= '0;
                    end else if (WDT_ON && own_stb && !resp) begin
                        // A response on the final wait cycle takes priority over the abort.
                        if (wdt == WDT_LAST) begin
                            state   <= S_ABORT;
                            timeout <= 1'b1;
                            wdt     <= '0;
                        end else begin
                            wdt <= wdt + WW'(1);
                        end
                    end else begin
                        wdt <= '0;
                    end
                end
                S_ABORT: begin
                    state <= S_IDLE;
                    grant <= '0;
                    wdt   <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                    wdt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter_wdt.sv
// Self-checking bench for wb_rr_arbiter_wdt with 4 masters, 32-bit bus and TIMEOUT=16.
// The bench drives the masters and the slave cycle by cycle. A rotation model picks
// the expected owner, and a per-beat wait count predicts ack versus watchdog abort.
module tb_wb_rr_arbiter_wdt;
    localparam int TMO = 16;

    localparam int M_WAITG = 0;
    localparam int M_SERVE = 1;
    localparam int M_DROP  = 2;
    localparam int M_ABORT = 3;
    localparam int M_GAP   = 4;
    localparam int M_DONE  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_rr_arbiter_wdt_if #(.NUM_MASTERS(4), .aw(32), .dw(32)) bus ();

    wb_rr_arbiter_wdt #(.NUM_MASTERS(4), .aw(32), .dw(32), .TIMEOUT(TMO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_adr [4];
    logic [31:0] m_dat [4];
    logic [3:0]  m_sel [4];
    logic [2:0]  m_cti [4];
    logic [3:0]  m_we;
    logic [3:0]  m_cyc;
    logic [3:0]  m_stb;
    int          r_dly [4];
    int          r_nb  [4];
    bit          r_hold[4];
    int          m_last;
    int          dtab  [7] = '{0, 1, 2, 3, 5, 15, 16};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    // Next owner from the rotation rule: first pending master after the last winner.
    function automatic int pick(input int last, input logic [3:0] p);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (p[c]) return c;
        end
        return 0;
    endfunction

    task automatic drive_bus();
        for (int i = 0; i < 4; i++) begin
            bus.wbm_adr_i[i*32 +: 32] = m_adr[i];
            bus.wbm_dat_i[i*32 +: 32] = m_dat[i];
            bus.wbm_sel_i[i*4 +: 4]   = m_sel[i];
            bus.wbm_cti_i[i*3 +: 3]   = m_cti[i];
            bus.wbm_bte_i[i*2 +: 2]   = 2'b00;
        end
        bus.wbm_we_i  = m_we;
        bus.wbm_cyc_i = m_cyc;
        bus.wbm_stb_i = m_stb;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        m_cyc = '0;
        m_stb = '0;
        for (int i = 0; i < 4; i++) m_cti[i] = 3'b000;
        bus.wbs_ack_i = 1'b0;
        bus.wbs_err_i = 1'b0;
        bus.wbs_rty_i = 1'b0;
        bus.wbs_rdt_i = '0;
        drive_bus();
        @(posedge clk);
        #1;
        chk("rst_grant", 128'(bus.grant_o), 128'(0));
        chk("rst_bus", 128'({bus.wbs_cyc_o, bus.wbs_stb_o, bus.timeout_o, bus.wbm_ack_o,
                              bus.wbm_err_o, bus.wbm_rty_o}), 128'(0));
        rst    = 1'b0;
        m_last = 3;
    endtask

    // Run one round: every master in mask raises cyc and performs r_nb beats.
    task automatic run_round(input logic [3:0] mask);
        logic [3:0]  pend;
        logic [31:0] rdt;
        int  o, n, left, guard, mode;
        bit  ackd, adv;
        pend = mask;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                m_cyc[i] = 1'b1;
                m_stb[i] = 1'b1;
                m_cti[i] = (r_nb[i] > 1) ? 3'b010 : 3'b000;
            end
        end
        drive_bus();
        mode = M_WAITG;
        o = 0; n = 0; left = 0; guard = 0; adv = 1'b0;
        while (mode != M_DONE && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
            if (mode == M_WAITG) begin
                o      = pick(m_last, pend);
                m_last = o;
                chk("new_grant", 128'(bus.grant_o), 128'(onehot(o)));
                n = 0; left = r_nb[o]; adv = 1'b0;
                m_cti[o] = (left > 1) ? 3'b010 : 3'b000;
                drive_bus();
                mode = M_SERVE;
            end
            case (mode)
                M_SERVE: begin
                    if (adv) begin
                        m_adr[o] = m_adr[o] + 32'd4;
                        if (left == 1) m_cti[o] = 3'b111;
                        drive_bus();
                        adv = 1'b0;
                    end
                    chk("own_grant", 128'(bus.grant_o), 128'(onehot(o)));
                    chk("tmo_quiet", 128'(bus.timeout_o), 128'(0));
                    ackd = (n == r_dly[o]);
                    rdt  = $urandom;
                    bus.wbs_ack_i = ackd;
                    bus.wbs_rdt_i = rdt;
                    #1;
                    chk("wbs_cyc_stb", 128'({bus.wbs_cyc_o, bus.wbs_stb_o}), 128'(2'b11));
                    chk("wbs_adr", 128'(bus.wbs_adr_o), 128'(m_adr[o]));
                    chk("wbs_ctl", 128'({bus.wbs_we_o, bus.wbs_sel_o, bus.wbs_cti_o, bus.wbs_dat_o}),
                        128'({m_we[o], m_sel[o], m_cti[o], m_dat[o]}));
                    chk("ack_route", 128'(bus.wbm_ack_o), ackd ? 128'(onehot(o)) : 128'(0));
                    chk("err_route", 128'(bus.wbm_err_o), 128'(0));
                    chk("rdt_bcast", 128'(bus.wbm_rdt_o), 128'({4{rdt}}));
                    if (ackd) begin
                        left--;
                        n = 0;
                        if (left == 0) mode = M_DROP;
                        else adv = 1'b1;
                    end else begin
                        n++;
                        if (n == TMO) mode = M_ABORT;
                    end
                end
                M_DROP: begin
                    bus.wbs_ack_i = 1'b0;
                    m_cyc[o] = 1'b0;
                    m_stb[o] = 1'b0;
                    m_cti[o] = 3'b000;
                    drive_bus();
                    pend[o] = 1'b0;
                    #1;
                    chk("drop_cyc", 128'(bus.wbs_cyc_o), 128'(0));
                    chk("drop_ack", 128'(bus.wbm_ack_o), 128'(0));
                    mode = M_GAP;
                end
                M_ABORT: begin
                    chk("tmo_pulse", 128'(bus.timeout_o), 128'(1));
                    chk("abort_grant", 128'(bus.grant_o), 128'(onehot(o)));
                    bus.wbs_ack_i = 1'b1;
                    #1;
                    chk("abort_cyc", 128'({bus.wbs_cyc_o, bus.wbs_stb_o}), 128'(0));
                    chk("abort_err", 128'(bus.wbm_err_o), 128'(onehot(o)));
                    chk("late_ack", 128'(bus.wbm_ack_o), 128'(0));
                    if (r_hold[o]) begin
                        r_hold[o] = 1'b0;
                        r_dly[o]  = 0;
                    end else begin
                        m_cyc[o] = 1'b0;
                        m_stb[o] = 1'b0;
                        m_cti[o] = 3'b000;
                        drive_bus();
                        pend[o] = 1'b0;
                    end
                    mode = M_GAP;
                end
                M_GAP: begin
                    bus.wbs_ack_i = 1'b0;
                    chk("gap_grant", 128'(bus.grant_o), 128'(0));
                    chk("gap_tmo", 128'(bus.timeout_o), 128'(0));
                    #1;
                    chk("gap_cyc", 128'(bus.wbs_cyc_o), 128'(0));
                    mode = (pend != 4'b0000) ? M_WAITG : M_DONE;
                end
                default: ;
            endcase
        end
        chk("round_done", 128'(mode == M_DONE), 128'(1));
    endtask

    task automatic set_master(input int i, input logic [31:0] a, input int dly, input int nb);
        m_adr[i]  = a;
        m_dat[i]  = $urandom;
        m_sel[i]  = 4'($urandom_range(0, 15));
        m_we[i]   = 1'($urandom_range(0, 1));
        r_dly[i]  = dly;
        r_nb[i]   = nb;
        r_hold[i] = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_time_limit reached");
        $fatal(1);
    end

    initial begin
        m_we = '0;
        m_cyc = '0;
        m_stb = '0;
        for (int i = 0; i < 4; i++) begin
            m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0; m_cti[i] = '0;
            r_dly[i] = 0;  r_nb[i] = 1;   r_hold[i] = 1'b0;
        end
        m_last = 3;
        repeat (2) @(posedge clk);
        #1;

        // Master 2 alone writes 0xA5A5_0000 to 0x08.
        apply_reset();
        set_master(2, 32'h0000_0008, 0, 1);
        m_dat[2] = 32'hA5A5_0000;
        m_we[2]  = 1'b1;
        m_sel[2] = 4'hF;
        run_round(4'b0100);

        // All four masters issue single accesses, twice, starting from reset.
        apply_reset();
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 4; i++) set_master(i, 32'h100 * i, rep, 1);
            run_round(4'b1111);
        end

        // Master 1 runs an 8-beat burst while master 3 waits.
        apply_reset();
        set_master(1, 32'h0000_2000, 0, 8);
        set_master(3, 32'h0000_3000, 1, 1);
        run_round(4'b1010);

        // Master 0 is never acked and gets a watchdog err; master 1 is granted next.
        apply_reset();
        set_master(0, 32'h0000_0040, 20, 1);
        set_master(1, 32'h0000_0044, 0, 1);
        run_round(4'b0011);

        // An ack on the final wait cycle beats the watchdog.
        apply_reset();
        set_master(0, 32'h0000_0080, TMO - 1, 1);
        run_round(4'b0001);

        // Aborted master keeps cyc and re-arbitrates behind the others.
        apply_reset();
        set_master(0, 32'h0000_00C0, TMO, 1);
        set_master(2, 32'h0000_00C4, 2, 2);
        r_hold[0] = 1'b1;
        run_round(4'b0101);

        // Reset asserted in the middle of a burst.
        apply_reset();
        set_master(0, 32'h0000_0400, 0, 8);
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        m_cti[0] = 3'b010;
        drive_bus();
        bus.wbs_ack_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("burst_grant", 128'(bus.grant_o), 128'(4'b0001));
        chk("burst_ack", 128'(bus.wbm_ack_o), 128'(4'b0001));
        rst = 1'b1;
        #1;
        chk("midrst_regs", 128'({bus.grant_o, bus.timeout_o}), 128'(0));
        chk("midrst_bus", 128'({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbm_ack_o, bus.wbm_err_o}),
            128'(0));
        apply_reset();
        set_master(0, 32'h0000_0500, 1, 1);
        set_master(1, 32'h0000_0600, 0, 1);
        run_round(4'b0011);

        // Randomized rounds.
        for (int r = 0; r < 30; r++) begin
            logic [3:0] mask;
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                set_master(i, $urandom & 32'hFFFF_FFFC, dtab[$urandom_range(0, 6)],
                           $urandom_range(1, 3));
                r_hold[i] = 1'($urandom_range(0, 1));
            end
            run_round(mask);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
